// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller for a single-issue core.
// It holds the M-mode trap CSRs and synchronizes the external interrupt lines.
// Each cycle it picks one event in the EXE stage: exception, then interrupt,
// then MRET, then CSR access. A trap or MRET drives a one-cycle registered
// redirect to the core. The cycle of that redirect is a bubble.

module trap_ctrl #(
    parameter int               XLEN        = 64,
    parameter int               NIRQ        = 4,
    parameter logic [XLEN-1:0]  MTVEC_RESET = {XLEN{1'b0}},
    parameter logic             MIE_RESET   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                exec_valid,
    input  logic [XLEN-1:0]     pc_in,
    input  logic [1:0]          csr_op,
    input  logic [11:0]         csr_addr,
    input  logic [XLEN-1:0]     csr_wdata,
    output logic [XLEN-1:0]     csr_rdata,
    output logic                csr_illegal,
    input  logic                mret,
    input  logic                exc_valid,
    input  logic [4:0]          exc_cause,
    input  logic [NIRQ-1:0]     irq_req,
    output logic [NIRQ-1:0]     irq_ack,
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;

    localparam logic [1:0]  OP_NONE = 2'b00;
    localparam logic [1:0]  OP_RW   = 2'b01;
    localparam logic [1:0]  OP_RS   = 2'b10;
    localparam logic [1:0]  OP_RC   = 2'b11;

    // Return the lowest set index of a pending vector. The caller checks that at least one bit is set.
    function automatic logic [4:0] lowest_index(input logic [NIRQ-1:0] vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            idx = vec[i] ? 5'(i) : idx;
        end
        return idx;
    endfunction

    // Synchronizer stages and architectural state
    logic [NIRQ-1:0] irq_meta_q;
    logic [NIRQ-1:0] irq_sync_q;
    logic            mstatus_mie_q;
    logic            mstatus_mpie_q;
    logic [NIRQ-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [NIRQ-1:0] irq_ack_q;

    // Combinational decode
    logic [XLEN-1:0] mstatus_s;
    logic [XLEN-1:0] mie_view_s;
    logic [XLEN-1:0] mip_view_s;
    logic [XLEN-1:0] rdata_s;
    logic            implemented_s;
    logic            illegal_s;
    logic            active_s;
    logic [NIRQ-1:0] pending_s;
    logic            exc_take_s;
    logic            irq_take_s;
    logic            mret_take_s;
    logic            csr_take_s;
    logic            csr_wr_en_s;
    logic [XLEN-1:0] csr_new_s;
    logic [4:0]      irq_idx_s;
    logic [4:0]      irq_code_s;
    logic [NIRQ-1:0] irq_onehot_s;
    logic [XLEN-1:0] trap_base_s;
    logic [XLEN-1:0] target_d;
    logic [XLEN-1:0] mcause_d;

    // Assemble CSR views and read mux. Unimplemented addresses read zero.
    always_comb begin
        mstatus_s     = {XLEN{1'b0}};
        mstatus_s[3]  = mstatus_mie_q;
        mstatus_s[7]  = mstatus_mpie_q;
        mie_view_s    = {XLEN{1'b0}};
        mie_view_s[16 +: NIRQ] = mie_q;
        mip_view_s    = {XLEN{1'b0}};
        mip_view_s[16 +: NIRQ] = irq_sync_q;
        rdata_s       = {XLEN{1'b0}};
        implemented_s = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:  rdata_s = mstatus_s;
            ADDR_MIE:      rdata_s = mie_view_s;
            ADDR_MIP:      rdata_s = mip_view_s;
            ADDR_MTVEC:    rdata_s = mtvec_q;
            ADDR_MSCRATCH: rdata_s = mscratch_q;
            ADDR_MEPC:     rdata_s = mepc_q;
            ADDR_MCAUSE:   rdata_s = mcause_q;
            default: begin
                rdata_s       = {XLEN{1'b0}};
                implemented_s = 1'b0;
            end
        endcase
        illegal_s = (csr_op != OP_NONE) && !implemented_s;
    end

    // Arbitrate events in EXE. During the redirect cycle nothing commits.
    always_comb begin
        active_s    = exec_valid && !redirect_valid_q;
        pending_s   = irq_sync_q & mie_q;
        exc_take_s  = active_s && exc_valid;
        irq_take_s  = active_s && !exc_valid && mstatus_mie_q && (pending_s != {NIRQ{1'b0}});
        mret_take_s = active_s && !exc_take_s && !irq_take_s && mret;
        csr_take_s  = active_s && !exc_take_s && !irq_take_s && !mret_take_s
                      && (csr_op != OP_NONE) && !illegal_s;
        // A set or clear with a zero mask is only a read.
        csr_wr_en_s = csr_take_s && ((csr_op == OP_RW) || (csr_wdata != {XLEN{1'b0}}));
        case (csr_op)
            OP_RW:   csr_new_s = csr_wdata;
            OP_RS:   csr_new_s = rdata_s | csr_wdata;
            OP_RC:   csr_new_s = rdata_s & ~csr_wdata;
            default: csr_new_s = rdata_s;
        endcase
    end

    // Select the interrupt and build the cause and redirect target.
    always_comb begin
        irq_idx_s  = lowest_index(pending_s);
        irq_code_s = 5'd16 + irq_idx_s;
        for (int i = 0; i < NIRQ; i++) begin
            irq_onehot_s[i] = (irq_idx_s == 5'(i));
        end
        trap_base_s = {mtvec_q[XLEN-1:2], 2'b00};
        if (exc_take_s) begin
            mcause_d = {1'b0, {(XLEN-6){1'b0}}, exc_cause};
            target_d = trap_base_s;
        end else if (irq_take_s) begin
            mcause_d = {1'b1, {(XLEN-6){1'b0}}, irq_code_s};
            // Vectored mode offsets by 4*cause. The sum wraps at XLEN bits.
            if (mtvec_q[1:0] == 2'b01) begin
                target_d = trap_base_s + {{(XLEN-7){1'b0}}, irq_code_s, 2'b00};
            end else begin
                target_d = trap_base_s;
            end
        end else begin
            mcause_d = mcause_q;
            target_d = mepc_q;
        end
    end

    // Two-flop synchronizer for the asynchronous interrupt levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_meta_q <= {NIRQ{1'b0}};
            irq_sync_q <= {NIRQ{1'b0}};
        end else begin
            irq_meta_q <= irq_req;
            irq_sync_q <= irq_meta_q;
        end
    end

    // CSR state. Trap entry, MRET and CSR writes are mutually exclusive by arbitration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstatus_mie_q  <= MIE_RESET;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= {NIRQ{1'b0}};
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= {XLEN{1'b0}};
            mepc_q         <= {XLEN{1'b0}};
            mcause_q       <= {XLEN{1'b0}};
        end else if (exc_take_s || irq_take_s) begin
            mepc_q         <= pc_in;
            mcause_q       <= mcause_d;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (mret_take_s) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (csr_wr_en_s) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie_q  <= csr_new_s[3];
                    mstatus_mpie_q <= csr_new_s[7];
                end
                ADDR_MIE:      mie_q      <= csr_new_s[16 +: NIRQ];
                // Modes 2 and 3 are reserved and are stored as direct mode.
                ADDR_MTVEC:    mtvec_q    <= csr_new_s[1] ? {csr_new_s[XLEN-1:2], 2'b00} : csr_new_s;
                ADDR_MSCRATCH: mscratch_q <= csr_new_s;
                ADDR_MEPC:     mepc_q     <= {csr_new_s[XLEN-1:1], 1'b0};
                ADDR_MCAUSE:   mcause_q   <= csr_new_s;
                default: begin
                    // mip is read-only. Writes to it are dropped.
                    mepc_q <= mepc_q;
                end
            endcase
        end
    end

    // Registered redirect and acknowledge pulses, one cycle after the committing edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {XLEN{1'b0}};
            irq_ack_q        <= {NIRQ{1'b0}};
        end else begin
            redirect_valid_q <= exc_take_s || irq_take_s || mret_take_s;
            if (exc_take_s || irq_take_s || mret_take_s) begin
                redirect_pc_q <= target_d;
            end
            irq_ack_q <= irq_take_s ? irq_onehot_s : {NIRQ{1'b0}};
        end
    end

    assign csr_rdata      = rdata_s;
    assign csr_illegal    = illegal_s;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign irq_ack        = irq_ack_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl with hand-computed expected values.
module tb_trap_ctrl;

    localparam int XLEN = 64;
    localparam int NIRQ = 4;

    localparam logic [1:0]  OP_NONE = 2'b00;
    localparam logic [1:0]  OP_RW   = 2'b01;
    localparam logic [1:0]  OP_RS   = 2'b10;
    localparam logic [1:0]  OP_RC   = 2'b11;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;

    logic            clk;
    logic            reset;
    logic            exec_valid;
    logic [XLEN-1:0] pc_in;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            mret;
    logic            exc_valid;
    logic [4:0]      exc_cause;
    logic [NIRQ-1:0] irq_req;
    logic [NIRQ-1:0] irq_ack;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    int n_checks;
    int n_pass;

    trap_ctrl #(.XLEN(XLEN), .NIRQ(NIRQ), .MTVEC_RESET(64'h0), .MIE_RESET(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .exec_valid     (exec_valid),
        .pc_in          (pc_in),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .mret           (mret),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .irq_req        (irq_req),
        .irq_ack        (irq_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        csr_op   = OP_NONE;
        csr_addr = addr;
        #1;
        check_eq(tag, csr_rdata, exp);
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] data);
        exec_valid = 1'b1;
        csr_op     = op;
        csr_addr   = addr;
        csr_wdata  = data;
        step();
        exec_valid = 1'b0;
        csr_op     = OP_NONE;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b0;
        exec_valid = 1'b0;
        pc_in      = 64'h0;
        csr_op     = OP_NONE;
        csr_addr   = 12'h0;
        csr_wdata  = 64'h0;
        mret       = 1'b0;
        exc_valid  = 1'b0;
        exc_cause  = 5'd0;
        irq_req    = 4'b0000;

        // Reset values
        step();
        step();
        check_eq("rst_rv", {63'h0, redirect_valid}, 64'h0);
        check_eq("rst_ack", {60'h0, irq_ack}, 64'h0);
        chk_csr("rst_mstatus", A_MSTATUS, 64'h8);
        chk_csr("rst_mtvec", A_MTVEC, 64'h0);
        chk_csr("rst_mie", A_MIE, 64'h0);
        chk_csr("rst_mepc", A_MEPC, 64'h0);
        reset = 1'b1;
        step();

        // Direct-mode interrupt on line 0
        csr_wr(OP_RW, A_MTVEC, 64'h100);
        csr_wr(OP_RW, A_MIE, 64'h10000);
        chk_csr("mie_set", A_MIE, 64'h10000);
        irq_req    = 4'b0001;
        exec_valid = 1'b1;
        pc_in      = 64'h80000010;
        step();
        check_eq("irq0_edge1_rv", {63'h0, redirect_valid}, 64'h0);
        step();
        check_eq("irq0_edge2_rv", {63'h0, redirect_valid}, 64'h0);
        step();
        check_eq("irq0_rv", {63'h0, redirect_valid}, 64'h1);
        check_eq("irq0_pc", redirect_pc, 64'h100);
        check_eq("irq0_ack", {60'h0, irq_ack}, 64'h1);
        chk_csr("irq0_mepc", A_MEPC, 64'h80000010);
        chk_csr("irq0_mcause", A_MCAUSE, 64'h8000000000000010);
        chk_csr("irq0_mstatus", A_MSTATUS, 64'h80);
        step();
        check_eq("irq0_rv_drop", {63'h0, redirect_valid}, 64'h0);
        check_eq("irq0_ack_drop", {60'h0, irq_ack}, 64'h0);
        step();
        check_eq("irq0_masked", {63'h0, redirect_valid}, 64'h0);

        // MRET restores MIE. The held request then re-traps after the bubble.
        csr_wr(OP_RW, A_MEPC, 64'h80000021);
        chk_csr("mepc_bit0", A_MEPC, 64'h80000020);
        exec_valid = 1'b1;
        mret       = 1'b1;
        pc_in      = 64'h80000030;
        step();
        mret = 1'b0;
        check_eq("mret_rv", {63'h0, redirect_valid}, 64'h1);
        check_eq("mret_pc", redirect_pc, 64'h80000020);
        check_eq("mret_ack", {60'h0, irq_ack}, 64'h0);
        chk_csr("mret_mstatus", A_MSTATUS, 64'h88);
        step();
        check_eq("mret_bubble", {63'h0, redirect_valid}, 64'h0);
        step();
        check_eq("retrap_rv", {63'h0, redirect_valid}, 64'h1);
        check_eq("retrap_ack", {60'h0, irq_ack}, 64'h1);
        check_eq("retrap_pc", redirect_pc, 64'h100);
        chk_csr("retrap_mepc", A_MEPC, 64'h80000030);
        irq_req    = 4'b0000;
        exec_valid = 1'b0;
        step(); step(); step();

        // Reserved mtvec modes and a vectored interrupt on line 2
        csr_wr(OP_RW, A_MTVEC, 64'h303);
        chk_csr("mtvec_mode3", A_MTVEC, 64'h300);
        csr_wr(OP_RS, A_MSTATUS, 64'h8);
        csr_wr(OP_RW, A_MTVEC, 64'h201);
        chk_csr("mtvec_vec", A_MTVEC, 64'h201);
        csr_wr(OP_RS, A_MIE, 64'h40000);
        chk_csr("mie_two", A_MIE, 64'h50000);
        irq_req    = 4'b0100;
        exec_valid = 1'b1;
        pc_in      = 64'h80000050;
        step(); step();
        check_eq("irq2_early", {63'h0, redirect_valid}, 64'h0);
        step();
        check_eq("irq2_rv", {63'h0, redirect_valid}, 64'h1);
        check_eq("irq2_pc", redirect_pc, 64'h248);
        check_eq("irq2_ack", {60'h0, irq_ack}, 64'h4);
        chk_csr("irq2_mcause", A_MCAUSE, 64'h8000000000000012);
        irq_req    = 4'b0000;
        exec_valid = 1'b0;
        step(); step(); step();

        // An exception beats a pending interrupt in the same cycle
        csr_wr(OP_RS, A_MSTATUS, 64'h8);
        irq_req = 4'b0001;
        step(); step();
        exec_valid = 1'b1;
        exc_valid  = 1'b1;
        exc_cause  = 5'd2;
        pc_in      = 64'h80000040;
        step();
        exc_valid = 1'b0;
        exec_valid = 1'b0;
        check_eq("exc_rv", {63'h0, redirect_valid}, 64'h1);
        check_eq("exc_pc", redirect_pc, 64'h200);
        check_eq("exc_ack", {60'h0, irq_ack}, 64'h0);
        chk_csr("exc_mcause", A_MCAUSE, 64'h2);
        chk_csr("exc_mepc", A_MEPC, 64'h80000040);
        chk_csr("exc_mstatus", A_MSTATUS, 64'h80);
        irq_req = 4'b0000;
        step(); step(); step();

        // CSRRS with a zero mask is only a read. CSRRC clears MIE and blocks interrupts.
        exec_valid = 1'b1;
        csr_op     = OP_RS;
        csr_addr   = A_MIE;
        csr_wdata  = 64'h0;
        #1;
        check_eq("rs0_rdata", csr_rdata, 64'h50000);
        step();
        exec_valid = 1'b0;
        csr_op     = OP_NONE;
        chk_csr("rs0_mie", A_MIE, 64'h50000);
        csr_wr(OP_RS, A_MSTATUS, 64'h8);
        chk_csr("rs_mstatus", A_MSTATUS, 64'h88);
        csr_wr(OP_RC, A_MSTATUS, 64'h8);
        chk_csr("rc_mstatus", A_MSTATUS, 64'h80);
        irq_req    = 4'b0001;
        exec_valid = 1'b1;
        step(); step(); step(); step();
        check_eq("rc_no_trap", {63'h0, redirect_valid}, 64'h0);
        check_eq("rc_no_ack", {60'h0, irq_ack}, 64'h0);
        irq_req    = 4'b0000;
        exec_valid = 1'b0;
        step(); step(); step();

        // Illegal CSR access changes nothing. mip is read-only.
        csr_wr(OP_RW, A_MSCRATCH, 64'h1234);
        exec_valid = 1'b1;
        csr_op     = OP_RW;
        csr_addr   = 12'h7C0;
        csr_wdata  = 64'hFFFF;
        #1;
        check_eq("ill_flag", {63'h0, csr_illegal}, 64'h1);
        check_eq("ill_rdata", csr_rdata, 64'h0);
        step();
        check_eq("ill_rv", {63'h0, redirect_valid}, 64'h0);
        exec_valid = 1'b0;
        csr_op     = OP_NONE;
        #1;
        check_eq("ill_noop_flag", {63'h0, csr_illegal}, 64'h0);
        chk_csr("ill_mscratch", A_MSCRATCH, 64'h1234);
        chk_csr("ill_mstatus", A_MSTATUS, 64'h80);
        csr_wr(OP_RW, A_MIP, 64'hFFFFFFFF);
        chk_csr("mip_ro", A_MIP, 64'h0);

        // Reset asserted during the redirect cycle
        csr_wr(OP_RS, A_MSTATUS, 64'h8);
        exec_valid = 1'b1;
        exc_valid  = 1'b1;
        exc_cause  = 5'd5;
        pc_in      = 64'h80000060;
        step();
        exec_valid = 1'b0;
        exc_valid  = 1'b0;
        check_eq("prerst_rv", {63'h0, redirect_valid}, 64'h1);
        reset = 1'b0;
        #1;
        check_eq("midrst_rv", {63'h0, redirect_valid}, 64'h0);
        check_eq("midrst_ack", {60'h0, irq_ack}, 64'h0);
        chk_csr("midrst_mstatus", A_MSTATUS, 64'h8);
        chk_csr("midrst_mepc", A_MEPC, 64'h0);
        chk_csr("midrst_mscratch", A_MSCRATCH, 64'h0);
        chk_csr("midrst_mtvec", A_MTVEC, 64'h0);
        chk_csr("midrst_mie", A_MIE, 64'h0);
        step();
        reset = 1'b1;
        step();
        check_eq("postrst_rv", {63'h0, redirect_valid}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
